// File: rtl/pm_pkt_arbiter.sv
// Two-source Avalon-ST packet arbiter: packet-atomic round-robin grant onto one
// output stream, with packet and missing-sop counters.
module pm_pkt_arbiter #(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned EMPTY_WIDTH = 6
) (
    input  logic                   Clk,
    input  logic                   Rst_n,

    input  logic [DATA_WIDTH-1:0]  in0_data,
    input  logic [EMPTY_WIDTH-1:0] in0_empty,
    input  logic                   in0_sop,
    input  logic                   in0_eop,
    input  logic                   in0_valid,
    output logic                   in0_ready,

    input  logic [DATA_WIDTH-1:0]  in1_data,
    input  logic [EMPTY_WIDTH-1:0] in1_empty,
    input  logic                   in1_sop,
    input  logic                   in1_eop,
    input  logic                   in1_valid,
    output logic                   in1_ready,

    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   out_valid,
    input  logic                   out_ready,

    output logic [31:0]            stats_in0_pkt,
    output logic [31:0]            stats_in1_pkt,
    output logic [31:0]            stats_out_pkt,
    output logic [31:0]            stats_nosop
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_gnt_q;
    logic   first_q;
    logic   out_xfer;

    assign out_xfer = out_valid & out_ready;

    // Grant decision and combinational mux of the granted source onto out.
    always_comb begin
        state_d   = state_q;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        out_data  = '0;
        out_empty = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (in0_valid) begin
                    state_d = GNT0;
                end else if (in1_valid) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                out_data  = in0_data;
                out_empty = in0_empty;
                out_sop   = in0_sop;
                out_eop   = in0_eop;
                out_valid = in0_valid;
                in0_ready = out_ready;
                if (in0_valid && out_ready && in0_eop) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                out_data  = in1_data;
                out_empty = in1_empty;
                out_sop   = in1_sop;
                out_eop   = in1_eop;
                out_valid = in1_valid;
                in1_ready = out_ready;
                if (in1_valid && out_ready && in1_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin history and first-beat-of-grant marker.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            first_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == GNT0) begin
                last_gnt_q <= 1'b0;
            end else if (state_q == IDLE && state_d == GNT1) begin
                last_gnt_q <= 1'b1;
            end
            if (state_q == IDLE) begin
                first_q <= (state_d != IDLE);
            end else if (out_xfer) begin
                first_q <= 1'b0;
            end
        end
    end

    // Free-running wrapping counters.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stats_in0_pkt <= '0;
            stats_in1_pkt <= '0;
            stats_out_pkt <= '0;
            stats_nosop   <= '0;
        end else begin
            if (in0_valid && in0_ready && in0_eop) begin
                stats_in0_pkt <= stats_in0_pkt + 32'd1;
            end
            if (in1_valid && in1_ready && in1_eop) begin
                stats_in1_pkt <= stats_in1_pkt + 32'd1;
            end
            if (out_xfer && out_eop) begin
                stats_out_pkt <= stats_out_pkt + 32'd1;
            end
            if (out_xfer && first_q && !out_sop) begin
                stats_nosop <= stats_nosop + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pm_pkt_arbiter.sv
// Scoreboard bench for pm_pkt_arbiter: per-source expected FIFOs, packet-level
// counter model, and per-cycle grant traces for the directed scenarios.
`timescale 1ns/1ps
module tb_pm_pkt_arbiter;

    localparam int unsigned DW = 512;
    localparam int unsigned EW = 6;

    typedef struct {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [DW-1:0] in0_data, in1_data, out_data;
    logic [EW-1:0] in0_empty, in1_empty, out_empty;
    logic          in0_sop, in0_eop, in0_valid, in0_ready;
    logic          in1_sop, in1_eop, in1_valid, in1_ready;
    logic          out_sop, out_eop, out_valid, out_ready;
    logic [31:0]   stats_in0_pkt, stats_in1_pkt, stats_out_pkt, stats_nosop;

    pm_pkt_arbiter #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in0_data(in0_data), .in0_empty(in0_empty), .in0_sop(in0_sop), .in0_eop(in0_eop),
        .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_empty(in1_empty), .in1_sop(in1_sop), .in1_eop(in1_eop),
        .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_empty(out_empty), .out_sop(out_sop), .out_eop(out_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .stats_in0_pkt(stats_in0_pkt), .stats_in1_pkt(stats_in1_pkt),
        .stats_out_pkt(stats_out_pkt), .stats_nosop(stats_nosop)
    );

    always #5 Clk = ~Clk;

    beat_t       stim0[$], stim1[$], exp0[$], exp1[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned vpct0 = 100;
    int unsigned vpct1 = 100;
    int          rdy_mode = 0;
    int          seq = 0;
    logic [31:0] m_in0 = '0, m_in1 = '0, m_out = '0, m_nosop = '0;
    int          cyc_trace[$], xfer_trace[$], want[$];
    bit          trace_en = 1'b0;
    bit          in_pkt = 1'b0;
    bit          prev_eop = 1'b0;
    int          cur_src = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_trace(input string name, input bit use_xfer);
        int n;
        for (int i = 0; i < want.size(); i++) begin
            if (use_xfer) n = (i < xfer_trace.size()) ? xfer_trace[i] : -1;
            else          n = (i < cyc_trace.size())  ? cyc_trace[i]  : -1;
            chk32($sformatf("%s[%0d]", name, i), 32'(n), 32'(want[i]));
        end
    endtask

    function automatic beat_t mk_beat(input int src, input bit sop, input bit eop);
        beat_t b;
        for (int w = 0; w < int'(DW / 32); w++) b.data[w*32 +: 32] = $urandom();
        b.data[DW-1]      = src[0];
        b.data[DW-2 -: 16] = 16'(seq);
        b.empty = EW'($urandom_range(63));
        b.sop   = sop;
        b.eop   = eop;
        seq++;
        return b;
    endfunction

    // Issue one packet: push to stimulus and expected queues, update model counts.
    task automatic add_pkt(input int src, input int len, input bit drop_sop);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = mk_beat(src, (i == 0) && !drop_sop, i == len - 1);
            if (src == 0) begin stim0.push_back(b); exp0.push_back(b); end
            else          begin stim1.push_back(b); exp1.push_back(b); end
        end
        if (src == 0) m_in0 = m_in0 + 32'd1;
        else          m_in1 = m_in1 + 32'd1;
        m_out = m_out + 32'd1;
        if (drop_sop) m_nosop = m_nosop + 32'd1;
    endtask

    task automatic rst_assert();
        Rst_n = 1'b0;
        #1;
        stim0.delete(); stim1.delete(); exp0.delete(); exp1.delete();
        m_in0 = '0; m_in1 = '0; m_out = '0; m_nosop = '0;
        trace_en = 1'b0;
        cyc_trace.delete(); xfer_trace.delete();
    endtask

    task automatic rst_release();
        @(posedge Clk); #3;
        Rst_n    = 1'b1;
        trace_en = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((stim0.size() + stim1.size() + exp0.size() + exp1.size()) != 0 && n < budget) begin
            @(posedge Clk);
            n++;
        end
        chk32("drain", 32'(stim0.size() + stim1.size() + exp0.size() + exp1.size()), 32'd0);
        repeat (2) @(posedge Clk);
        #3;
    endtask

    task automatic chk_counters(input string tag);
        chk32({tag, " stats_in0_pkt"}, stats_in0_pkt, m_in0);
        chk32({tag, " stats_in1_pkt"}, stats_in1_pkt, m_in1);
        chk32({tag, " stats_out_pkt"}, stats_out_pkt, m_out);
        chk32({tag, " stats_nosop"},   stats_nosop,   m_nosop);
    endtask

    // Source and sink driver: handshake judged at negedge, inputs updated after posedge.
    initial begin : driver
        bit a0, a1;
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        in0_data = '0; in0_empty = '0; in0_sop = 1'b0; in0_eop = 1'b0;
        in1_data = '0; in1_empty = '0; in1_sop = 1'b0; in1_eop = 1'b0;
        forever begin
            @(negedge Clk);
            a0 = in0_valid && in0_ready;
            a1 = in1_valid && in1_ready;
            @(posedge Clk); #1;
            if (a0 && stim0.size() > 0) void'(stim0.pop_front());
            if (a1 && stim1.size() > 0) void'(stim1.pop_front());
            if (stim0.size() > 0 && $urandom_range(99) < vpct0) begin
                in0_valid = 1'b1; in0_data = stim0[0].data; in0_empty = stim0[0].empty;
                in0_sop = stim0[0].sop; in0_eop = stim0[0].eop;
            end else begin
                in0_valid = 1'b0;
            end
            if (stim1.size() > 0 && $urandom_range(99) < vpct1) begin
                in1_valid = 1'b1; in1_data = stim1[0].data; in1_empty = stim1[0].empty;
                in1_sop = stim1[0].sop; in1_eop = stim1[0].eop;
            end else begin
                in1_valid = 1'b0;
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = ($urandom_range(99) < 70);
            endcase
        end
    end

    // Monitor: scoreboard pop on each out transfer plus grant-exclusivity checks.
    initial begin : monitor
        beat_t e;
        int    tag;
        bit    have;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                in_pkt   = 1'b0;
                prev_eop = 1'b0;
                continue;
            end
            checks++;
            if (in0_ready && in1_ready) begin
                errors++;
                $display("FAIL ready_excl: in0_ready %b in1_ready %b want not both", in0_ready, in1_ready);
            end
            if (in_pkt) begin
                checks++;
                if ((cur_src == 0 && in1_ready) || (cur_src == 1 && in0_ready)) begin
                    errors++;
                    $display("FAIL midpkt_ready: src%0d in packet, in0_ready %b in1_ready %b", cur_src, in0_ready, in1_ready);
                end
            end
            if (prev_eop) begin
                checks++;
                if (out_valid) begin
                    errors++;
                    $display("FAIL bubble: out_valid %b after eop want 0", out_valid);
                end
            end
            prev_eop = 1'b0;
            tag = int'(out_data[DW-1]);
            if (trace_en) cyc_trace.push_back(out_valid ? tag : 2);
            if (out_valid && out_ready) begin
                if (trace_en) xfer_trace.push_back(tag);
                if (in_pkt) begin
                    checks++;
                    if (tag != cur_src) begin
                        errors++;
                        $display("FAIL atomic: got beat of src%0d want src%0d mid-packet", tag, cur_src);
                    end
                end
                have = 1'b0;
                if (tag == 0 && exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
                if (tag == 1 && exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL beat: got unexpected beat src%0d seq %0h, want none", tag, out_data[DW-2 -: 16]);
                end else if (out_data !== e.data || out_empty !== e.empty ||
                             out_sop !== e.sop || out_eop !== e.eop) begin
                    errors++;
                    $display("FAIL beat src%0d: got seq %0h sop %b eop %b empty %0d, want seq %0h sop %b eop %b empty %0d",
                             tag, out_data[DW-2 -: 16], out_sop, out_eop, out_empty,
                             e.data[DW-2 -: 16], e.sop, e.eop, e.empty);
                end
                in_pkt   = !out_eop;
                cur_src  = tag;
                prev_eop = out_eop;
            end
        end
    end

    initial begin : main
        Rst_n = 1'b1;
        #1;
        rst_assert();
        repeat (2) @(posedge Clk);
        #3;
        chk32("rst out_valid", 32'(out_valid), 32'd0);
        chk32("rst out_sop",   32'(out_sop),   32'd0);
        chk32("rst out_eop",   32'(out_eop),   32'd0);
        chk32("rst in0_ready", 32'(in0_ready), 32'd0);
        chk32("rst in1_ready", 32'(in1_ready), 32'd0);
        chk_counters("rst");

        // Two 3-beat packets from reset: src0 first, one idle cycle, then src1.
        vpct0 = 100; vpct1 = 100; rdy_mode = 0;
        add_pkt(0, 3, 1'b0);
        add_pkt(1, 3, 1'b0);
        rst_release();
        wait_drain(200);
        want = '{2, 0, 0, 0, 2, 1, 1, 1, 2};
        chk_trace("tie3", 1'b0);
        chk_counters("tie3");

        // Back-to-back single-beat packets on both sources alternate with bubbles.
        @(posedge Clk); #3;
        rst_assert();
        for (int i = 0; i < 6; i++) begin
            add_pkt(0, 1, 1'b0);
            add_pkt(1, 1, 1'b0);
        end
        rst_release();
        wait_drain(200);
        want.delete();
        for (int i = 0; i < 6; i++) begin
            want.push_back(2); want.push_back(0); want.push_back(2); want.push_back(1);
        end
        chk_trace("alt", 1'b0);
        chk32("alt in0 vs in1", stats_in0_pkt, stats_in1_pkt);
        chk_counters("alt");

        // 4-beat src1 packet under toggling out_ready; src0 arrives mid-packet.
        @(posedge Clk); #3;
        rst_assert();
        rdy_mode = 1;
        add_pkt(1, 4, 1'b0);
        rst_release();
        repeat (3) @(posedge Clk);
        #3;
        add_pkt(0, 2, 1'b0);
        wait_drain(200);
        want = '{1, 1, 1, 1, 0, 0};
        chk_trace("toggle", 1'b1);
        chk_counters("toggle");

        // Missing sop on first beat is forwarded and counted.
        @(posedge Clk); #3;
        rst_assert();
        rdy_mode = 0;
        add_pkt(0, 2, 1'b1);
        rst_release();
        wait_drain(200);
        chk_counters("nosop");

        // Randomised traffic: valid gaps, random backpressure, occasional missing sop.
        @(posedge Clk); #3;
        rst_assert();
        vpct0 = 60; vpct1 = 80; rdy_mode = 2;
        rst_release();
        for (int i = 0; i < 30; i++) begin
            add_pkt(0, 1 + int'($urandom_range(4)), $urandom_range(9) == 0);
            add_pkt(1, 1 + int'($urandom_range(4)), $urandom_range(9) == 0);
        end
        wait_drain(5000);
        chk_counters("random");

        // Output packet counter wraps from all-ones to zero.
        vpct0 = 100; vpct1 = 100; rdy_mode = 0;
        @(negedge Clk);
        force dut.stats_out_pkt = 32'hFFFF_FFFF;
        #1;
        release dut.stats_out_pkt;
        m_out = 32'hFFFF_FFFF;
        chk32("wrap preload", stats_out_pkt, m_out);
        add_pkt(1, 1, 1'b0);
        wait_drain(200);
        chk32("wrap stats_out_pkt", stats_out_pkt, m_out);

        // Reset on beat 2 of a 5-beat packet clears everything immediately.
        add_pkt(0, 5, 1'b0);
        begin
            int n = 0;
            while (exp0.size() > 3 && n < 200) begin
                @(posedge Clk);
                n++;
            end
            chk32("midreset reach beat2", 32'(exp0.size()), 32'd3);
        end
        #3;
        rst_assert();
        chk32("midreset out_valid", 32'(out_valid), 32'd0);
        chk32("midreset out_sop",   32'(out_sop),   32'd0);
        chk32("midreset out_eop",   32'(out_eop),   32'd0);
        chk32("midreset in0_ready", 32'(in0_ready), 32'd0);
        chk32("midreset in1_ready", 32'(in1_ready), 32'd0);
        chk_counters("midreset");
        add_pkt(1, 1, 1'b0);
        add_pkt(0, 1, 1'b0);
        rst_release();
        wait_drain(200);
        want = '{2, 0, 2, 1};
        chk_trace("postreset tie", 1'b0);
        chk_counters("postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pm_pkt_arbiter.md
PM_PKT_ARBITER -- requirements
Module: pm_pkt_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 512, meaning the Avalon-ST data bus width in bits.
REQ-002 The block SHALL have parameter EMPTY_WIDTH, default 6, meaning the width of the empty-byte field.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port Rst_n  input  1  asynchronous, active-low reset.
REQ-006 Ports in0_data/in0_empty/in0_sop/in0_eop/in0_valid  input  DATA_WIDTH/EMPTY_WIDTH/1/1/1  source 0 (fast-path nocheck) stream.
REQ-007 Port in0_ready  output  1  backpressure to source 0.
REQ-008 Ports in1_data/in1_empty/in1_sop/in1_eop/in1_valid  input  DATA_WIDTH/EMPTY_WIDTH/1/1/1  source 1 (checked-packet) stream.
REQ-009 Port in1_ready  output  1  backpressure to source 1.
REQ-010 Ports out_data/out_empty/out_sop/out_eop/out_valid  output  DATA_WIDTH/EMPTY_WIDTH/1/1/1  merged stream.
REQ-011 Port out_ready  input  1  downstream backpressure; readyLatency 0.
REQ-012 Ports stats_in0_pkt, stats_in1_pkt, stats_out_pkt, stats_nosop  output  32 each  packet and error counters.

Function
REQ-013 Beat transfer on any interface SHALL occur only on a cycle where valid and ready are both high.
REQ-014 The FSM SHALL have states IDLE, GNT0, GNT1; reset state IDLE.
REQ-015 In IDLE, in0_ready and in1_ready SHALL be 0 and out_valid SHALL be 0.
REQ-016 In IDLE, with only inX_valid high, the next state SHALL be GNTX.
REQ-017 In IDLE, with both valids high, the grant SHALL go to the source not recorded in register last_gnt; last_gnt resets to 1, so source 0 wins the first tie.
REQ-018 On entering GNTX, last_gnt SHALL be set to X.
REQ-019 In GNTX, out_data/empty/sop/eop/valid SHALL equal the inX fields combinationally, inX_ready SHALL equal out_ready, and the other source's ready SHALL be 0.
REQ-020 In GNTX, a transfer with inX_eop high SHALL return the FSM to IDLE next cycle; grant is packet-atomic and no source switch occurs mid-packet.
REQ-021 Arbitration latency SHALL be exactly one cycle: the first beat of a granted packet appears on out no earlier than the cycle after the IDLE decision cycle, giving one idle cycle between consecutive packets.
REQ-022 Single-beat packets (sop and eop together) SHALL transfer in one GNTX cycle and then return to IDLE.
REQ-023 stats_inX_pkt SHALL increment by 1 on each inX transfer with eop high.
REQ-024 stats_out_pkt SHALL increment by 1 on each out transfer with eop high.
REQ-025 stats_nosop SHALL increment by 1 when the first transfer after entering GNTX has sop low; that beat SHALL still be forwarded unchanged.
REQ-026 All counters SHALL wrap from 0xFFFFFFFF to 0 without saturation.
REQ-027 out_ready held low in GNTX SHALL hold the state and all counters, with no beat lost or duplicated.
REQ-028 inX_valid dropping mid-packet in GNTX SHALL keep the grant; out_valid follows inX_valid.

Reset
REQ-029 Asserting Rst_n low SHALL immediately force the FSM to IDLE, last_gnt to 1, all ready outputs, out_valid, out_sop and out_eop to 0, and all stats counters to 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; the block performs no recovery of the truncated packet downstream.
REQ-031 Reset deassertion SHALL be synchronised by the integrator; the block's first arbitration occurs on the first Clk edge with Rst_n high.

Verification
REQ-032 Both sources present a 3-beat packet from reset, out_ready=1 -> in0 packet occupies out cycles 1-3, idle cycle 4, in1 packet on cycles 5-7; stats_out_pkt=2.
REQ-033 Both sources stream continuous 1-beat packets, out_ready=1 -> output alternates 0,1,0,1 with one bubble between each; stats_in0_pkt equals stats_in1_pkt within 1.
REQ-034 in1 packet of 4 beats with out_ready toggled 1,0,1,0 per cycle -> 4 beats delivered in order, in0 never granted mid-packet, in0_ready stays 0 throughout.
REQ-035 Source 0 first beat sent with sop=0 -> beat forwarded unchanged and stats_nosop=1.
REQ-036 Rst_n pulsed low on beat 2 of a 5-beat packet -> next cycle out_valid=0, all readies 0, all counters 0; after release a tie grants source 0.
REQ-037 stats_out_pkt preloaded via 2^32-1 single-beat packets (or a forced value of 0xFFFFFFFF) then one more packet -> counter reads 0.
